paint_sprite_blitter: RTL and testbench

//  Copies one rectangular sprite region from sprite ROM into the frame-buffer write port, one pixel per clock.

---
 rtl/paint_sprite_blitter_pkg.sv | 39 +++
 rtl/paint_sprite_blitter_if.sv | 34 +++
 rtl/paint_sprite_blitter_delay_line.sv | 27 ++
 rtl/paint_sprite_blitter.sv | 136 +++++++++++++
 tb/tb_paint_sprite_blitter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/paint_sprite_blitter_pkg.sv
// rtl/paint_sprite_blitter_pkg.sv - shared types and constants for the sprite blitter
// Purpose: coordinate/palette types, FSM state enum, latched job record, frame and sheet geometry.
// Ports: none (package).
package paint_sprite_blitter_pkg;

  localparam int COOR_WIDTH   = 12;
  localparam int ROM_WIDTH    = 19;
  localparam int PAL_WIDTH    = 2;
  localparam int SPRITE_WIDTH = 2446;
  localparam int FRAME_WIDTH  = 1280;
  localparam int FRAME_HEIGHT = 300;

  typedef logic [COOR_WIDTH-1:0]      coord_t;
  typedef logic signed [COOR_WIDTH:0] scoord_t;
  typedef logic [PAL_WIDTH-1:0]       pal_t;
  typedef logic [ROM_WIDTH-1:0]       rom_addr_t;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} blit_state_e;

  typedef struct packed {
    coord_t sprite_x;
    coord_t sprite_y;
    coord_t frame_x;
    coord_t frame_y;
    coord_t width;
    coord_t height;
    logic   flip_x;
  } job_t;

  // Signed frame base plus unsigned element offset, one bit wider than a coordinate.
  function automatic scoord_t frame_coord(input coord_t base, input coord_t off);
    scoord_t b;
    scoord_t o;
    b = {base[COOR_WIDTH-1], base};
    o = {1'b0, off};
    return b + o;
  endfunction

endpackage

// File: rtl/paint_sprite_blitter_if.sv
// rtl/paint_sprite_blitter_if.sv - job, sprite ROM and frame write signals of the blitter
// Purpose: bundles the compositor job handshake, the ROM read port and the frame-RAM write port.
// Modports: master = compositor/ROM/frame side, slave = blitter.
interface paint_sprite_blitter_if;
  import paint_sprite_blitter_pkg::*;

  logic      start;
  coord_t    sprite_x;
  coord_t    sprite_y;
  coord_t    frame_x;
  coord_t    frame_y;
  coord_t    width;
  coord_t    height;
  logic      flip_x;
  logic      busy;
  logic      done;
  rom_addr_t rom_addr;
  pal_t      rom_data;
  logic      write_en;
  coord_t    write_x;
  coord_t    write_y;
  pal_t      write_palette;

  modport master (
    output start, sprite_x, sprite_y, frame_x, frame_y, width, height, flip_x, rom_data,
    input  busy, done, rom_addr, write_en, write_x, write_y, write_palette
  );

  modport slave (
    input  start, sprite_x, sprite_y, frame_x, frame_y, width, height, flip_x, rom_data,
    output busy, done, rom_addr, write_en, write_x, write_y, write_palette
  );

endinterface

// File: rtl/paint_sprite_blitter_delay_line.sv
// rtl/paint_sprite_blitter_delay_line.sv - resettable shift register of DEPTH stages
// Purpose: carries {valid,x,y} alongside the ROM read so it lines up with rom_data.
// Ports: clk_i, rst_i (sync, active-high), din_i [WIDTH], dout_o [WIDTH] = din_i delayed DEPTH cycles.
module paint_sprite_blitter_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/paint_sprite_blitter.sv
// rtl/paint_sprite_blitter.sv - copies a sprite rectangle from sprite ROM to the frame write port
// Purpose: one pixel per clock, with flip, clipping to the frame and transparent-index skipping.
// Ports: clk_33m, rst (sync, active-high); bus (slave): start/job fields in, busy/done out,
//        rom_addr out / rom_data in (ROM_LATENCY later), write_en/write_x/write_y/write_palette out.
module paint_sprite_blitter
  import paint_sprite_blitter_pkg::*;
#(
  parameter int ROM_LATENCY     = 1,
  parameter bit TRANSPARENT_EN  = 1'b1,
  parameter int TRANSPARENT_IDX = 0
) (
  input logic                   clk_33m,
  input logic                   rst,
  paint_sprite_blitter_if.slave bus
);

  localparam int DRAIN_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam int PIPE_W  = 1 + 2 * COOR_WIDTH;

  blit_state_e          state_q;
  job_t                 job_q;
  job_t                 job_d;
  coord_t               x_q;
  coord_t               y_q;
  logic [DRAIN_W-1:0]   drain_q;

  logic                 accept;
  coord_t               last_x;
  coord_t               last_y;
  coord_t               sx;

  logic [PIPE_W-1:0]    pipe_in;
  logic [PIPE_W-1:0]    pipe_out;
  logic                 pipe_valid;
  coord_t               pipe_x;
  coord_t               pipe_y;
  scoord_t              fx;
  scoord_t              fy;
  logic                 in_frame;
  logic                 transparent;
  logic                 wr;

  // The DONE cycle reports busy=0, so a new job may be taken there back-to-back.
  assign accept = bus.start && (state_q == IDLE || state_q == DONE);

  assign job_d = '{sprite_x: bus.sprite_x, sprite_y: bus.sprite_y,
                   frame_x:  bus.frame_x,  frame_y:  bus.frame_y,
                   width:    bus.width,    height:   bus.height,
                   flip_x:   bus.flip_x};

  assign last_x = job_q.width  - coord_t'(1);
  assign last_y = job_q.height - coord_t'(1);

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      state_q <= IDLE;
      job_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      drain_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (accept) begin
            job_q   <= job_d;
            x_q     <= '0;
            y_q     <= '0;
            state_q <= (bus.width == '0 || bus.height == '0) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (x_q == last_x) begin
            x_q <= '0;
            if (y_q == last_y) begin
              state_q <= DRAIN;
              drain_q <= '0;
            end else begin
              y_q <= y_q + coord_t'(1);
            end
          end else begin
            x_q <= x_q + coord_t'(1);
          end
        end
        DRAIN: begin
          // Hold off done until the last ROM read has come back and been written.
          if (drain_q == DRAIN_W'(ROM_LATENCY - 1)) state_q <= DONE;
          else drain_q <= drain_q + DRAIN_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == SCAN) || (state_q == DRAIN);
  assign bus.done = (state_q == DONE);

  // Mirroring only changes the ROM column; the frame column still runs 0..W-1.
  assign sx = job_q.flip_x ? (last_x - x_q) : x_q;

  assign bus.rom_addr = (state_q == SCAN)
      ? rom_addr_t'(32'(job_q.sprite_x) + 32'(sx)
                    + (32'(job_q.sprite_y) + 32'(y_q)) * 32'(SPRITE_WIDTH))
      : '0;

  assign pipe_in = {(state_q == SCAN), x_q, y_q};

  paint_sprite_blitter_delay_line #(
    .WIDTH (PIPE_W),
    .DEPTH (ROM_LATENCY)
  ) u_delay (
    .clk_i  (clk_33m),
    .rst_i  (rst),
    .din_i  (pipe_in),
    .dout_o (pipe_out)
  );

  assign {pipe_valid, pipe_x, pipe_y} = pipe_out;

  // job_q is stable here: a new job can only be latched after DRAIN has emptied the pipe.
  assign fx = frame_coord(job_q.frame_x, pipe_x);
  assign fy = frame_coord(job_q.frame_y, pipe_y);

  assign in_frame = (fx >= scoord_t'(0)) && (fx < scoord_t'(FRAME_WIDTH))
                 && (fy >= scoord_t'(0)) && (fy < scoord_t'(FRAME_HEIGHT));

  assign transparent = TRANSPARENT_EN && (bus.rom_data == pal_t'(TRANSPARENT_IDX));

  assign wr = pipe_valid && in_frame && !transparent;

  assign bus.write_en      = wr;
  assign bus.write_x       = wr ? fx[COOR_WIDTH-1:0] : '0;
  assign bus.write_y       = wr ? fy[COOR_WIDTH-1:0] : '0;
  assign bus.write_palette = wr ? bus.rom_data : '0;

endmodule

// File: tb/tb_paint_sprite_blitter.sv
// tb/tb_paint_sprite_blitter.sv - directed self-checking bench for paint_sprite_blitter
module tb_paint_sprite_blitter;
  import paint_sprite_blitter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  paint_sprite_blitter_if if1 ();
  paint_sprite_blitter_if if3 ();

  paint_sprite_blitter #(.ROM_LATENCY(1), .TRANSPARENT_EN(1'b1), .TRANSPARENT_IDX(0)) dut1 (
    .clk_33m (clk), .rst (rst), .bus (if1.slave));
  paint_sprite_blitter #(.ROM_LATENCY(3), .TRANSPARENT_EN(1'b1), .TRANSPARENT_IDX(0)) dut3 (
    .clk_33m (clk), .rst (rst), .bus (if3.slave));

  // Job fields shared by both instances; each has its own start.
  logic   start1 = 1'b0;
  logic   start3 = 1'b0;
  coord_t j_sx, j_sy, j_fx, j_fy, j_w, j_h;
  logic   j_flip;
  coord_t alt_sx, alt_sy, alt_fx, alt_fy, alt_w, alt_h;

  assign if1.start = start1;  assign if3.start = start3;
  assign if1.sprite_x = j_sx; assign if3.sprite_x = j_sx;
  assign if1.sprite_y = j_sy; assign if3.sprite_y = j_sy;
  assign if1.frame_x = j_fx;  assign if3.frame_x = j_fx;
  assign if1.frame_y = j_fy;  assign if3.frame_y = j_fy;
  assign if1.width = j_w;     assign if3.width = j_w;
  assign if1.height = j_h;    assign if3.height = j_h;
  assign if1.flip_x = j_flip; assign if3.flip_x = j_flip;

  // Sprite ROM model: content indexed by the low address nibble.
  logic [1:0] mem [16];
  logic [1:0] r1_q = '0;
  logic [1:0] r3_q [3] = '{2'd0, 2'd0, 2'd0};
  always @(posedge clk) begin
    r1_q    <= mem[if1.rom_addr[3:0]];
    r3_q[0] <= mem[if3.rom_addr[3:0]];
    r3_q[1] <= r3_q[0];
    r3_q[2] <= r3_q[1];
  end
  assign if1.rom_data = r1_q;
  assign if3.rom_data = r3_q[2];

  int checks = 0;
  int passes = 0;
  int nw;
  logic        we_a [0:31];
  logic        dn_a [0:31];
  logic        bz_a [0:31];
  logic [31:0] ad_a [0:31];
  logic [31:0] wx_a [0:31];
  logic [31:0] wy_a [0:31];
  logic [31:0] wp_a [0:31];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_job(input int sx, input int sy, input int fx, input int fy,
                         input int w, input int h, input bit flip);
    j_sx = coord_t'(sx); j_sy = coord_t'(sy); j_fx = coord_t'(fx); j_fy = coord_t'(fy);
    j_w = coord_t'(w); j_h = coord_t'(h); j_flip = flip;
  endtask

  // Called at a negedge: pulses start, then records outputs in cycles 1..ncyc.
  // bz/rs: cycles in which start is pulsed again (bz also switches to the alt job fields).
  task automatic run(input int ncyc, input bit use3, input int bz, input int rs);
    nw = 0;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      we_a[c] = use3 ? if3.write_en : if1.write_en;
      dn_a[c] = use3 ? if3.done : if1.done;
      bz_a[c] = use3 ? if3.busy : if1.busy;
      ad_a[c] = 32'(use3 ? if3.rom_addr : if1.rom_addr);
      wx_a[c] = 32'(use3 ? if3.write_x : if1.write_x);
      wy_a[c] = 32'(use3 ? if3.write_y : if1.write_y);
      wp_a[c] = 32'(use3 ? if3.write_palette : if1.write_palette);
      if (we_a[c]) nw++;
      if (c == bz) begin
        j_sx = alt_sx; j_sy = alt_sy; j_fx = alt_fx; j_fy = alt_fy; j_w = alt_w; j_h = alt_h;
      end
      if (use3) start3 = (c == bz || c == rs); else start1 = (c == bz || c == rs);
    end
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'd1;
    set_job(0, 0, 0, 0, 0, 0, 1'b0);
    alt_sx = '0; alt_sy = '0; alt_fx = '0; alt_fy = '0; alt_w = '0; alt_h = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(if1.busy), 0);
    chk("rst_done", 32'(if1.done), 0);
    chk("rst_addr", 32'(if1.rom_addr), 0);
    chk("rst_we", 32'(if1.write_en), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: 4x2, no flip, frame (10,5), sprite (3,1), ROM all 1
    set_job(3, 1, 10, 5, 4, 2, 1'b0);
    run(12, 1'b0, 0, 0);
    chk("t1_busy1", 32'(bz_a[1]), 1);
    chk("t1_addr1", ad_a[1], 2449);
    chk("t1_addr5", ad_a[5], 4895);
    chk("t1_addr9", ad_a[9], 0);
    chk("t1_we1", 32'(we_a[1]), 0);
    chk("t1_we2", 32'(we_a[2]), 1);
    chk("t1_x2", wx_a[2], 10);
    chk("t1_y2", wy_a[2], 5);
    chk("t1_p2", wp_a[2], 1);
    chk("t1_x9", wx_a[9], 13);
    chk("t1_y9", wy_a[9], 6);
    chk("t1_nw", 32'(nw), 8);
    chk("t1_done9", 32'(dn_a[9]), 0);
    chk("t1_done10", 32'(dn_a[10]), 1);
    chk("t1_busy10", 32'(bz_a[10]), 0);
    chk("t1_done11", 32'(dn_a[11]), 0);

    // 2: left clip, frame_x = -2
    set_job(0, 0, -2, 0, 4, 1, 1'b0);
    run(8, 1'b0, 0, 0);
    chk("t2_we2", 32'(we_a[2]), 0);
    chk("t2_x2", wx_a[2], 0);
    chk("t2_we4", 32'(we_a[4]), 1);
    chk("t2_x4", wx_a[4], 0);
    chk("t2_x5", wx_a[5], 1);
    chk("t2_nw", 32'(nw), 2);
    chk("t2_done6", 32'(dn_a[6]), 1);

    // 3: flip, row {1,2,3} at addr 4..6
    mem[4] = 2'd1; mem[5] = 2'd2; mem[6] = 2'd3;
    set_job(4, 0, 0, 0, 3, 1, 1'b1);
    run(7, 1'b0, 0, 0);
    chk("t3_addr1", ad_a[1], 6);
    chk("t3_addr2", ad_a[2], 5);
    chk("t3_addr3", ad_a[3], 4);
    chk("t3_p2", wp_a[2], 3);
    chk("t3_x2", wx_a[2], 0);
    chk("t3_p3", wp_a[3], 2);
    chk("t3_p4", wp_a[4], 1);
    chk("t3_x4", wx_a[4], 2);
    chk("t3_done5", 32'(dn_a[5]), 1);

    // 4: transparent skipping, row {0,2,0,3} at addr 8..11
    mem[8] = 2'd0; mem[9] = 2'd2; mem[10] = 2'd0; mem[11] = 2'd3;
    set_job(8, 0, 0, 0, 4, 1, 1'b0);
    run(8, 1'b0, 0, 0);
    chk("t4_we2", 32'(we_a[2]), 0);
    chk("t4_we3", 32'(we_a[3]), 1);
    chk("t4_p3", wp_a[3], 2);
    chk("t4_we4", 32'(we_a[4]), 0);
    chk("t4_x5", wx_a[5], 3);
    chk("t4_p5", wp_a[5], 3);
    chk("t4_nw", 32'(nw), 2);
    chk("t4_done6", 32'(dn_a[6]), 1);

    // 5: latency 3, 2x2; ignored start in cycle 3, back-to-back 1x1 job in done cycle 8
    for (int i = 0; i < 16; i++) mem[i] = 2'd1;
    set_job(0, 0, 0, 0, 2, 2, 1'b0);
    alt_sx = coord_t'(0); alt_sy = coord_t'(0); alt_fx = coord_t'(5); alt_fy = coord_t'(6);
    alt_w = coord_t'(1); alt_h = coord_t'(1);
    run(15, 1'b1, 3, 8);
    chk("t5_we3", 32'(we_a[3]), 0);
    chk("t5_we4", 32'(we_a[4]), 1);
    chk("t5_we7", 32'(we_a[7]), 1);
    chk("t5_x7", wx_a[7], 1);
    chk("t5_y7", wy_a[7], 1);
    chk("t5_done7", 32'(dn_a[7]), 0);
    chk("t5_done8", 32'(dn_a[8]), 1);
    chk("t5_busy9", 32'(bz_a[9]), 1);
    chk("t5_x12", wx_a[12], 5);
    chk("t5_y12", wy_a[12], 6);
    chk("t5_done13", 32'(dn_a[13]), 1);
    chk("t5_nw", 32'(nw), 5);

    // 6a: reset mid-SCAN
    set_job(0, 0, 0, 0, 4, 2, 1'b0);
    run(3, 1'b0, 0, 0);
    chk("t6_busy3", 32'(bz_a[3]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rbusy", 32'(if1.busy), 0);
    chk("t6_rwe", 32'(if1.write_en), 0);
    chk("t6_rdone", 32'(if1.done), 0);
    chk("t6_raddr", 32'(if1.rom_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    // 6b: zero-width job
    set_job(0, 0, 0, 0, 0, 3, 1'b0);
    run(4, 1'b0, 0, 0);
    chk("t6_done1", 32'(dn_a[1]), 1);
    chk("t6_busy1", 32'(bz_a[1]), 0);
    chk("t6_addr1", ad_a[1], 0);
    chk("t6_done2", 32'(dn_a[2]), 0);
    chk("t6_nw", 32'(nw), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
